// File: rtl/controller_interface.sv
// controller_interface: polls two NES-style pads at vblank and serves the
// latched button bytes to the CPU at 0x7002 (pad 1) and 0x7003 (pad 2).

// One pad lane: a shift register that fills during a poll, and a held copy
// that the CPU reads. The held copy only changes on commit, so CPU reads
// never see a half-filled byte.
module controller_lane #(
    parameter int NUM_BUTTONS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   sample,
    input  logic [2:0]             bit_idx,
    input  logic                   data_n,
    input  logic                   commit,
    output logic [NUM_BUTTONS-1:0] held_q
);
    logic [NUM_BUTTONS-1:0] shift_q;

    // Capture one button per sample strobe; the pad line is active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      shift_q          <= '0;
        else if (clear)  shift_q          <= '0;
        else if (sample) shift_q[bit_idx] <= ~data_n;
    end

    // Publish the completed byte in one step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      held_q <= '0;
        else if (commit) held_q <= shift_q;
    end
endmodule

module controller_interface #(
    parameter int CLK_DIV     = 6,
    parameter int NUM_BUTTONS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_poll,
    input  logic       controller_data_1,
    input  logic       controller_data_2,
    output logic       controller_latch,
    output logic       controller_clk,
    input  logic       SELECT_controller,
    input  logic       address_bit0,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       poll_done
);
    localparam int NUM_PADS = 2;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LOW, SHIFT_HIGH, DONE} state_t;

    state_t     state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0] bit_cnt;
    logic       div_last;
    logic       clear, sample, commit;

    logic [NUM_PADS-1:0]                  pad_data;
    logic [NUM_PADS-1:0][NUM_BUTTONS-1:0] held;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign clear    = (state == IDLE) && start_poll;
    assign sample   = div_last && ((state == LATCH) || (state == SHIFT_HIGH));
    assign commit   = (state == DONE);
    assign pad_data = {controller_data_2, controller_data_1};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: each serial phase lasts CLK_DIV cycles; start_poll only
    // matters in IDLE, so requests during a poll are dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (start_poll) next_state = LATCH;
            LATCH:      if (div_last)   next_state = SHIFT_LOW;
            SHIFT_LOW:  if (div_last)   next_state = SHIFT_HIGH;
            SHIFT_HIGH: if (div_last)   next_state = (bit_cnt == 3'd7) ? DONE : SHIFT_LOW;
            DONE:                       next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // Outputs decoded from state only, so pad strobes are glitch-free.
    always_comb begin
        controller_latch = 1'b0;
        controller_clk   = 1'b1;
        busy             = 1'b1;
        poll_done        = 1'b0;
        case (state)
            IDLE:      busy             = 1'b0;
            LATCH:     controller_latch = 1'b1;
            SHIFT_LOW: controller_clk   = 1'b0;
            DONE:      poll_done        = 1'b1;
            default:   ;
        endcase
    end

    // Phase divider: restarts at every phase boundary and while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           div_cnt <= '0;
        else if ((state == IDLE) || div_last) div_cnt <= '0;
        else                                  div_cnt <= div_cnt + DIV_W'(1);
    end

    // Bit counter: the latch phase yields bit 7 (count 0), each clock-high
    // phase yields bit 7-count, so one index formula covers both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  bit_cnt <= '0;
        else if (state == IDLE)                      bit_cnt <= '0;
        else if (sample && (bit_cnt != 3'd7))        bit_cnt <= bit_cnt + 3'd1;
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
        controller_lane #(.NUM_BUTTONS(NUM_BUTTONS)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .sample  (sample),
            .bit_idx (3'd7 - bit_cnt),
            .data_n  (pad_data[p]),
            .commit  (commit),
            .held_q  (held[p])
        );
    end

    // Side-effect-free read mux.
    assign data_out = SELECT_controller ? held[address_bit0] : 8'h00;
endmodule

// File: tb/tb_controller_interface.sv
// Directed bench for controller_interface with behavioural NES pads.
module tb_controller_interface;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_poll = 1'b0;
    logic       controller_data_1, controller_data_2;
    logic       controller_latch, controller_clk;
    logic       SELECT_controller = 1'b1;
    logic       address_bit0 = 1'b0;
    logic [7:0] data_out;
    logic       busy, poll_done;

    int checks = 0;
    int failures = 0;

    // Pad models: pressed pattern, connection flag, line shift register.
    logic [7:0] p1 = 8'h00, p2 = 8'h00;
    logic       conn1 = 1'b1, conn2 = 1'b0;
    logic [7:0] lvl1 = 8'hFF, lvl2 = 8'hFF;

    controller_interface #(.CLK_DIV(6), .NUM_BUTTONS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_poll        (start_poll),
        .controller_data_1 (controller_data_1),
        .controller_data_2 (controller_data_2),
        .controller_latch  (controller_latch),
        .controller_clk    (controller_clk),
        .SELECT_controller (SELECT_controller),
        .address_bit0      (address_bit0),
        .data_out          (data_out),
        .busy              (busy),
        .poll_done         (poll_done)
    );

    always #5 clk = ~clk;

    // Latch loads the inverted buttons; each rising shift clock moves the next one out.
    always @(posedge controller_latch or posedge controller_clk) begin
        if (controller_latch) begin
            lvl1 <= ~p1;
            lvl2 <= ~p2;
        end else begin
            lvl1 <= {lvl1[6:0], 1'b1};
            lvl2 <= {lvl2[6:0], 1'b1};
        end
    end
    assign controller_data_1 = conn1 ? lvl1[7] : 1'b1;
    assign controller_data_2 = conn2 ? lvl2[7] : 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one poll from IDLE and watch 120 cycles; rN are cycles at which an
    // extra start_poll is raised (0 = none).
    task automatic run_poll(input int r1, input int r2, input int r3, input logic b0,
                            output int lat, output int lo, output int falls,
                            output int dcyc, output int dcnt,
                            output logic [7:0] rd40, output logic [7:0] rdd);
        logic prev_clk;
        lat = 0; lo = 0; falls = 0; dcyc = 0; dcnt = 0; rd40 = 8'hxx; rdd = 8'hxx;
        SELECT_controller = 1'b1;
        address_bit0 = b0;
        start_poll = 1'b1;
        @(negedge clk);
        start_poll = 1'b0;
        prev_clk = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            if (controller_latch) lat++;
            if (!controller_clk) lo++;
            if (prev_clk && !controller_clk) falls++;
            prev_clk = controller_clk;
            if (poll_done) begin
                dcnt++;
                if (dcyc == 0) begin
                    dcyc = k;
                    rdd  = data_out;
                end
            end
            if (k == 40) rd40 = data_out;
            start_poll = (k == r1) || (k == r2) || (k == r3);
            @(negedge clk);
        end
        start_poll = 1'b0;
    endtask

    task automatic read_at(input logic sel, input logic b0, input string tag, input logic [7:0] exp);
        SELECT_controller = sel;
        address_bit0 = b0;
        #1;
        check(tag, {24'h0, data_out}, {24'h0, exp});
    endtask

    int lat, lo, falls, dcyc, dcnt;
    logic [7:0] rd40, rdd;

    initial begin
        // Reset state.
        #2;
        check("rst_latch", {31'h0, controller_latch}, 32'h0);
        check("rst_clk", {31'h0, controller_clk}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, poll_done}, 32'h0);
        read_at(1'b1, 1'b0, "rst_rd1", 8'h00);
        read_at(1'b1, 1'b1, "rst_rd2", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic poll: pad 1 = 0x5A pressed, pad 2 disconnected.
        p1 = 8'h5A; conn1 = 1'b1; conn2 = 1'b0;
        run_poll(0, 0, 0, 1'b0, lat, lo, falls, dcyc, dcnt, rd40, rdd);
        check("a_latch_w", lat, 6);
        check("a_clk_low", lo, 42);
        check("a_clk_pulses", falls, 7);
        check("a_done_cyc", dcyc, 91);
        check("a_done_cnt", dcnt, 1);
        check("a_rd_in_done", {24'h0, rdd}, 32'h00);
        check("a_busy_after", {31'h0, busy}, 32'h0);
        read_at(1'b1, 1'b0, "a_rd1", 8'h5A);
        read_at(1'b1, 1'b1, "a_rd2", 8'h00);

        // Second poll with pad 1 = 0xFF; extra starts at 10, 90 and in DONE (91).
        p1 = 8'hFF;
        run_poll(10, 90, 91, 1'b0, lat, lo, falls, dcyc, dcnt, rd40, rdd);
        check("b_rd40", {24'h0, rd40}, 32'h5A);
        check("b_rd_in_done", {24'h0, rdd}, 32'h5A);
        check("b_done_cyc", dcyc, 91);
        check("b_done_cnt", dcnt, 1);
        check("b_latch_w", lat, 6);
        check("b_clk_pulses", falls, 7);
        read_at(1'b1, 1'b0, "b_rd1", 8'hFF);

        // Reset mid-poll at cycle 50.
        p1 = 8'h3C;
        @(negedge clk);
        start_poll = 1'b1;
        @(negedge clk);
        start_poll = 1'b0;
        repeat (49) @(negedge clk);
        check("m_busy_pre", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("m_latch", {31'h0, controller_latch}, 32'h0);
        check("m_clk", {31'h0, controller_clk}, 32'h1);
        check("m_busy", {31'h0, busy}, 32'h0);
        read_at(1'b1, 1'b0, "m_rd1", 8'h00);
        read_at(1'b1, 1'b1, "m_rd2", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh poll: pad 1 nothing pressed, pad 2 = 0x81.
        p1 = 8'h00; p2 = 8'h81; conn2 = 1'b1;
        run_poll(0, 0, 0, 1'b1, lat, lo, falls, dcyc, dcnt, rd40, rdd);
        check("c_done_cyc", dcyc, 91);
        read_at(1'b1, 1'b1, "c_rd2", 8'h81);
        read_at(1'b1, 1'b0, "c_rd1", 8'h00);

        // Both pads loaded, then deselect.
        p1 = 8'h5A; p2 = 8'h81;
        run_poll(0, 0, 0, 1'b0, lat, lo, falls, dcyc, dcnt, rd40, rdd);
        read_at(1'b1, 1'b0, "d_rd1", 8'h5A);
        read_at(1'b1, 1'b1, "d_rd2", 8'h81);
        read_at(1'b0, 1'b0, "d_desel0", 8'h00);
        read_at(1'b0, 1'b1, "d_desel1", 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
